// File: rtl/cpu_types_pkg.sv
// Shared types for the request unit: FSM states and the latched data-access op.
// Imported by request_unit and request_watchdog.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    HALTED
  } req_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } req_op_t;

endpackage

// File: rtl/request_watchdog.sv
// Wait-cycle watchdog for request_unit; compiled only with REQ_WATCHDOG_EN.
// Ports: clk, rst (sync, active-high), waiting, expire (comb), req_err (sticky).
`ifdef REQ_WATCHDOG_EN
module request_watchdog
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic expire,
  output logic req_err
);

  localparam int unsigned W = $clog2(TIMEOUT_MAX + 1);

  logic [W-1:0] cnt_q;

  // Fires on the wait cycle that brings the count to TIMEOUT_MAX.
  assign expire = waiting && (cnt_q == W'(TIMEOUT_MAX - 1));

  // A non-waiting cycle in FETCH/DATA is always a state entry or a
  // pc_en, so clearing on !waiting covers every restart point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      req_err <= 1'b0;
    end else begin
      if (!waiting) cnt_q <= '0;
      else          cnt_q <= cnt_q + W'(1);
      if (expire) req_err <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/request_unit.sv
// Turns decoded memory intent into I/D cache request strobes and gates PC commit on hits.
// Ports: CLK, RST (sync, active-high), memREN/memWEN/halt_in/ihit/dhit in;
//   iREN/dREN/dWEN/pc_en/halt/busy/stall_cnt/req_err out. Optional macro: REQ_WATCHDOG_EN.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned STALL_W     = 16,
  parameter int unsigned TIMEOUT_MAX = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               memREN,
  input  logic               memWEN,
  input  logic               halt_in,
  input  logic               ihit,
  input  logic               dhit,
  output logic               iREN,
  output logic               dREN,
  output logic               dWEN,
  output logic               pc_en,
  output logic               halt,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               req_err
);

  req_state_t state_q, state_d;
  req_op_t    op_q, op_d;
  logic       waiting;
  logic       wd_expire;

  assign waiting = (state_q == FETCH && !ihit)
                || (state_q == DATA && !dhit);

`ifdef REQ_WATCHDOG_EN
  request_watchdog #(
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_wd (
    .clk    (CLK),
    .rst    (RST),
    .waiting(waiting),
    .expire (wd_expire),
    .req_err(req_err)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_MAX != 0);
  assign wd_expire  = 1'b0;
  assign req_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_en   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (ihit) begin
          if (halt_in) begin
            state_d = HALTED;
          end else if (memREN || memWEN) begin
            // Both set is illegal decode; store wins.
            op_d.wr = memWEN;
            op_d.rd = memREN && !memWEN;
            state_d = DATA;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = FETCH;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (wd_expire) state_d = HALTED;
    if (RST)       pc_en   = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (waiting && !(&stall_cnt))
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign iREN = (state_q == FETCH);
  assign dREN = (state_q == DATA) && op_q.rd;
  assign dWEN = (state_q == DATA) && op_q.wr;
  assign halt = (state_q == HALTED);
  assign busy = iREN || dREN || dWEN;

  a_no_rd_wr: assert property (
    @(posedge CLK) disable iff (RST)
    (state_q == FETCH && ihit && !halt_in) |-> !(memREN && memWEN)
  ) else $error("request_unit: memREN and memWEN both set");

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed steps plus random instruction mix.
// Model works per instruction (kind, fetch waits, data waits), not per FSM state.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        memREN = 1'b0;
  logic        memWEN = 1'b0;
  logic        halt_in = 1'b0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        iREN, dREN, dWEN, pc_en, halt, busy, req_err;
  logic [15:0] stall_cnt;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned exp_stall = 0;

  typedef enum int {K_ALU, K_LD, K_ST} kind_e;

  always #5 CLK = ~CLK;

  request_unit #(
    .STALL_W    (16),
    .TIMEOUT_MAX(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .memREN   (memREN),
    .memWEN   (memWEN),
    .halt_in  (halt_in),
    .ihit     (ihit),
    .dhit     (dhit),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .pc_en    (pc_en),
    .halt     (halt),
    .busy     (busy),
    .stall_cnt(stall_cnt),
    .req_err  (req_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ei, input logic edr,
                         input logic edw, input logic epc, input logic eh,
                         input logic ee);
    chk({tag, ".iREN"}, 32'(iREN), 32'(ei));
    chk({tag, ".dREN"}, 32'(dREN), 32'(edr));
    chk({tag, ".dWEN"}, 32'(dWEN), 32'(edw));
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(epc));
    chk({tag, ".halt"}, 32'(halt), 32'(eh));
    chk({tag, ".busy"}, 32'(busy), 32'(ei | edr | edw));
    chk({tag, ".req_err"}, 32'(req_err), 32'(ee));
    chk({tag, ".stall"}, 32'(stall_cnt), exp_stall);
  endtask

  task automatic drive(input logic i, input logic d, input logic r,
                       input logic w, input logic h);
    @(negedge CLK);
    ihit = i; dhit = d; memREN = r; memWEN = w; halt_in = h;
    #1;
  endtask

  // Random mem intent that is never the illegal rd+wr combination.
  task automatic rnd_mem(output logic r, output logic w);
    r = 1'($urandom % 2);
    w = r ? 1'b0 : 1'($urandom % 2);
  endtask

  task automatic run_instr(input kind_e kind, input int nwi, input int nwd,
                           input bit stray);
    logic hit, r, w, i;
    for (int k = 0; k <= nwi; k++) begin
      hit = (k == nwi);
      if (hit) begin
        r = (kind == K_LD);
        w = (kind == K_ST);
      end else rnd_mem(r, w);
      drive(hit, 1'($urandom % 2), r, w, hit ? 1'b0 : 1'($urandom % 2));
      chk_out("fetch", 1, 0, 0, hit && kind == K_ALU, 0, 0);
      if (!hit) exp_stall++;
    end
    if (kind != K_ALU) begin
      for (int k = 0; k <= nwd; k++) begin
        hit = (k == nwd);
        rnd_mem(r, w);
        i = stray ? 1'b1 : 1'($urandom % 2);
        drive(i, hit, r, w, 1'($urandom % 2));
        chk_out("data", 0, kind == K_LD, kind == K_ST, hit, 0, 0);
        if (!hit) exp_stall++;
      end
    end
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST = 1'b0;
    ihit = 0; dhit = 0; memREN = 0; memWEN = 0; halt_in = 0;
    #1;
    exp_stall = 0;
    chk_out("idle", 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // 1. Reset for two cycles, all outputs low, one IDLE cycle after release
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      #1;
      exp_stall = 0;
      chk_out("rst", 0, 0, 0, 0, 0, 0);
    end
    release_rst();

    // 2. Non-memory instruction hits on first FETCH cycle
    run_instr(K_ALU, 0, 0, 0);
    // 3. Load, dhit after 3 wait cycles
    run_instr(K_LD, 0, 3, 0);
    // 4. Store with stray ihit throughout DATA
    run_instr(K_ST, 1, 2, 1);

    // Random instruction mix
    for (int n = 0; n < 60; n++) begin
      kind_e kd;
      kd = kind_e'($urandom_range(0, 2));
      run_instr(kd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    // RST mid-DATA: strobe holds until the edge, then IDLE
    drive(1, 0, 1, 0, 0);
    chk_out("mid.fetch", 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1; ihit = 0; dhit = 0; memREN = 0;
    #1;
    chk_out("mid.data", 0, 1, 0, 0, 0, 0);
    release_rst();

    // 5. Halt: sticky for 20 cycles with random inputs, then RST clears it
    drive(1, 0, 0, 0, 1);
    chk_out("halt.fetch", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      logic r, w;
      rnd_mem(r, w);
      drive(1'($urandom % 2), 1'($urandom % 2), r, w, 1'($urandom % 2));
      chk_out("halted", 0, 0, 0, 0, 1, 0);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_out("halt.rst", 0, 0, 0, 0, 1, 0);
    release_rst();

    // 6. ihit held low: watchdog expires after 4 waits when built in
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 0);
`ifdef REQ_WATCHDOG_EN
      if (k < 4) begin
        chk_out("wd.wait", 1, 0, 0, 0, 0, 0);
        exp_stall++;
      end else begin
        chk_out("wd.trip", 0, 0, 0, 0, 1, 1);
      end
`else
      chk_out("nowd.wait", 1, 0, 0, 0, 0, 0);
      exp_stall++;
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
